alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits; all requirements below use WIDTH=64.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-004 SHALL have port in_valid  input  1  operands and controls on this cycle are to be executed.
REQ-005 SHALL have port alu_op_1  input  1  ALUOp bit 1 from the control unit.
REQ-006 SHALL have port alu_op_0  input  1  ALUOp bit 0 from the control unit.
REQ-007 SHALL have port instruction_part  input  11  instruction[31:21] opcode field.
REQ-008 SHALL have port input_data_1  input  WIDTH  ALU operand A (register data 1).
REQ-009 SHALL have port input_data_2  input  WIDTH  ALU operand B (register data 2 or sign-extended immediate, already muxed).
REQ-010 SHALL have port old_pc  input  WIDTH  address of the current instruction.
REQ-011 SHALL have port sign_extend  input  WIDTH  sign-extended branch offset, in words.
REQ-012 SHALL have port branch  input  1  instruction is a conditional branch.
REQ-013 SHALL have port operation_code  output  4  decoded ALU operation, combinational.
REQ-014 SHALL have port out_valid  output  1  registered outputs hold a completed result.
REQ-015 SHALL have port output_data  output  WIDTH  registered ALU result.
REQ-016 SHALL have port output_zero  output  1  registered zero flag.
REQ-017 SHALL have port new_pc  output  WIDTH  registered next-PC.

Function
REQ-018 SHALL decode operation_code combinationally: alu_op_0=1 -> 0111 (pass B), regardless of alu_op_1.
REQ-019 SHALL decode alu_op_1=0, alu_op_0=0 -> 0010 (add), regardless of instruction_part.
REQ-020 SHALL decode alu_op_1=1, alu_op_0=0 via instruction_part: 10001011000 -> 0010 (ADD); 11001011000 -> 0110 (SUB); 10001010000 -> 0000 (AND); 10101010000 -> 0001 (ORR); any other value -> 1111.
REQ-021 SHALL compute the ALU result combinationally: 0000 A AND B; 0001 A OR B; 0010 A+B; 0110 A-B; 0111 B; 1100 NOR(A,B); any other code -> all zeros.
REQ-022 SHALL perform add/sub modulo 2^WIDTH, no carry/overflow outputs, two's-complement wrap.
REQ-023 SHALL set zero flag = 1 exactly when the WIDTH-bit ALU result equals 0.
REQ-024 SHALL compute pc_plus_4 = old_pc + 4 and branch_target = old_pc + (sign_extend << 2), both modulo 2^WIDTH, shift discarding the top 2 bits.
REQ-025 SHALL select next-PC = branch_target when (branch AND zero flag), else pc_plus_4.
REQ-026 SHALL, on a rising clock edge with in_valid=1, register ALU result, zero flag and next-PC into output_data, output_zero, new_pc and set out_valid=1.
REQ-027 SHALL, on a rising clock edge with in_valid=0, hold output_data, output_zero, new_pc and clear out_valid to 0.
REQ-028 SHALL have exactly one cycle latency from in_valid to out_valid; back-to-back in_valid each cycle SHALL produce a result every cycle, no stalls.

Reset
REQ-029 SHALL, while reset=0, immediately force output_data=0, output_zero=0, new_pc=0, out_valid=0, independent of clock.
REQ-030 SHALL ignore in_valid on any edge while reset=0; first capture occurs on the first rising edge after reset returns to 1.
REQ-031 SHALL keep operation_code purely combinational and unaffected by reset.

Verification
REQ-032 ADD: alu_op=10, instruction_part=10001011000, A=5, B=7, in_valid=1 -> operation_code=0010; next cycle output_data=12, output_zero=0, out_valid=1.
REQ-033 SUB wrap: alu_op=10, 11001011000, A=0, B=1 -> operation_code=0110; output_data=FFFF_FFFF_FFFF_FFFF, output_zero=0.
REQ-034 CBZ taken: alu_op=01, B=0, branch=1, old_pc=0x100, sign_extend=3 -> output_zero=1, new_pc=0x10C; with B=9 -> output_zero=0, new_pc=0x104.
REQ-035 Load/store address: alu_op=00, A=0x1000, B=0x18 -> output_data=0x1018; AND/ORR with A=0xF0, B=0x3C -> 0x30 / 0xFC; unknown opcode 11111111111 -> operation_code=1111, output_data=0, output_zero=1.
REQ-036 Reset mid-stream: assert reset=0 between clock edges after valid results -> all registered outputs 0 immediately; in_valid=1 during reset produces no out_valid; first edge after release captures new operands.

Source files
------------

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : alu_exec_unit
// Description : Execute stage. It decodes ALUOp and the opcode field into an
//               ALU operation, computes the result, the zero flag and the
//               next PC, and registers them with a one-cycle valid.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             alu_op_1,
  input  logic             alu_op_0,
  input  logic [10:0]      instruction_part,
  input  logic [WIDTH-1:0] input_data_1,
  input  logic [WIDTH-1:0] input_data_2,
  input  logic [WIDTH-1:0] old_pc,
  input  logic [WIDTH-1:0] sign_extend,
  input  logic             branch,
  output logic [3:0]       operation_code,
  output logic             out_valid,
  output logic [WIDTH-1:0] output_data,
  output logic             output_zero,
  output logic [WIDTH-1:0] new_pc
);

  localparam logic [3:0]  c_OP_AND  = 4'b0000;
  localparam logic [3:0]  c_OP_ORR  = 4'b0001;
  localparam logic [3:0]  c_OP_ADD  = 4'b0010;
  localparam logic [3:0]  c_OP_SUB  = 4'b0110;
  localparam logic [3:0]  c_OP_PASS = 4'b0111;
  localparam logic [3:0]  c_OP_NOR  = 4'b1100;
  localparam logic [3:0]  c_OP_BAD  = 4'b1111;

  localparam logic [10:0] c_OPC_ADD = 11'b10001011000;
  localparam logic [10:0] c_OPC_SUB = 11'b11001011000;
  localparam logic [10:0] c_OPC_AND = 11'b10001010000;
  localparam logic [10:0] c_OPC_ORR = 11'b10101010000;

  localparam logic [WIDTH-1:0] c_FOUR = WIDTH'(4);

  logic [3:0]       w_op;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic [WIDTH-1:0] next_pc_d;
  logic [WIDTH-1:0] w_pc_plus_4;
  logic [WIDTH-1:0] w_branch_target;

  logic             out_valid_q;
  logic [WIDTH-1:0] output_data_q;
  logic             output_zero_q;
  logic [WIDTH-1:0] new_pc_q;

  // ALU control: ALUOp bit 0 (CBZ) wins, then plain add, then R-type decode.
  always_comb begin
    w_op = c_OP_BAD;
    if (alu_op_0) begin
      w_op = c_OP_PASS;
    end else if (!alu_op_1) begin
      w_op = c_OP_ADD;
    end else begin
      case (instruction_part)
        c_OPC_ADD: w_op = c_OP_ADD;
        c_OPC_SUB: w_op = c_OP_SUB;
        c_OPC_AND: w_op = c_OP_AND;
        c_OPC_ORR: w_op = c_OP_ORR;
        default:   w_op = c_OP_BAD;
      endcase
    end
  end

  assign operation_code = w_op;

  // ALU datapath; unsupported codes yield zero so the zero flag is set.
  always_comb begin
    result_d = '0;
    case (w_op)
      c_OP_AND:  result_d = input_data_1 & input_data_2;
      c_OP_ORR:  result_d = input_data_1 | input_data_2;
      c_OP_ADD:  result_d = input_data_1 + input_data_2;
      c_OP_SUB:  result_d = input_data_1 - input_data_2;
      c_OP_PASS: result_d = input_data_2;
      c_OP_NOR:  result_d = ~(input_data_1 | input_data_2);
      default:   result_d = '0;
    endcase
  end

  assign zero_d          = (result_d == '0);
  assign w_pc_plus_4     = old_pc + c_FOUR;
  // The offset is in words; the shift drops the top two bits.
  assign w_branch_target = old_pc + {sign_extend[WIDTH-3:0], 2'b00};
  assign next_pc_d       = (branch && zero_d) ? w_branch_target : w_pc_plus_4;

  // Result register: capture on valid, otherwise hold data and drop valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      output_data_q <= '0;
      output_zero_q <= 1'b0;
      new_pc_q      <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        output_data_q <= result_d;
        output_zero_q <= zero_d;
        new_pc_q      <= next_pc_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign output_data = output_data_q;
  assign output_zero = output_zero_q;
  assign new_pc      = new_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int WIDTH = 64;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             alu_op_1;
  logic             alu_op_0;
  logic [10:0]      instruction_part;
  logic [WIDTH-1:0] input_data_1;
  logic [WIDTH-1:0] input_data_2;
  logic [WIDTH-1:0] old_pc;
  logic [WIDTH-1:0] sign_extend;
  logic             branch;
  logic [3:0]       operation_code;
  logic             out_valid;
  logic [WIDTH-1:0] output_data;
  logic             output_zero;
  logic [WIDTH-1:0] new_pc;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(WIDTH)) u_dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .alu_op_1         (alu_op_1),
    .alu_op_0         (alu_op_0),
    .instruction_part (instruction_part),
    .input_data_1     (input_data_1),
    .input_data_2     (input_data_2),
    .old_pc           (old_pc),
    .sign_extend      (sign_extend),
    .branch           (branch),
    .operation_code   (operation_code),
    .out_valid        (out_valid),
    .output_data      (output_data),
    .output_zero      (output_zero),
    .new_pc           (new_pc)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation after a falling edge, check the decode, then the
  // registered outputs just after the next rising edge.
  task automatic run_op(input string tag, input logic [1:0] aop, input logic [10:0] ip,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] pc, input logic [63:0] se, input logic br,
                        input logic [3:0] exp_op, input logic [63:0] exp_data,
                        input logic exp_zero, input logic [63:0] exp_pc);
    @(negedge clock);
    in_valid         = 1'b1;
    alu_op_1         = aop[1];
    alu_op_0         = aop[0];
    instruction_part = ip;
    input_data_1     = a;
    input_data_2     = b;
    old_pc           = pc;
    sign_extend      = se;
    branch           = br;
    #1;
    check_eq({tag, "_opcode"}, 64'(operation_code), 64'(exp_op));
    @(posedge clock);
    #1;
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_data"},  output_data, exp_data);
    check_eq({tag, "_zero"},  64'(output_zero), 64'(exp_zero));
    check_eq({tag, "_newpc"}, new_pc, exp_pc);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b1; alu_op_1 = 1'b0; alu_op_0 = 1'b0;
    instruction_part = '0; input_data_1 = 64'd1; input_data_2 = 64'd2;
    old_pc = '0; sign_extend = '0; branch = 1'b0;

    // Reset state, with in_valid held high across edges.
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data",  output_data, 64'd0);
    check_eq("rst_zero",  64'(output_zero), 64'd0);
    check_eq("rst_newpc", new_pc, 64'd0);
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;

    // Back-to-back directed vectors.
    run_op("add",   2'b10, 11'b10001011000, 64'd5, 64'd7, 64'h200, 64'd0, 1'b0,
           4'b0010, 64'd12, 1'b0, 64'h204);
    run_op("subwrap", 2'b10, 11'b11001011000, 64'd0, 64'd1, 64'h300, 64'd0, 1'b0,
           4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h304);
    run_op("cbz_tk", 2'b01, 11'b00000000000, 64'd55, 64'd0, 64'h100, 64'd3, 1'b1,
           4'b0111, 64'd0, 1'b1, 64'h10C);
    run_op("cbz_nt", 2'b01, 11'b00000000000, 64'd55, 64'd9, 64'h100, 64'd3, 1'b1,
           4'b0111, 64'd9, 1'b0, 64'h104);
    run_op("cbz_back", 2'b11, 11'b10001011000, 64'd1, 64'd0, 64'h100,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'b0111, 64'd0, 1'b1, 64'hFC);
    run_op("ldst",  2'b00, 11'b11001011000, 64'h1000, 64'h18, 64'h400, 64'd0, 1'b0,
           4'b0010, 64'h1018, 1'b0, 64'h404);
    run_op("and",   2'b10, 11'b10001010000, 64'hF0, 64'h3C, 64'h500, 64'd0, 1'b0,
           4'b0000, 64'h30, 1'b0, 64'h504);
    run_op("orr",   2'b10, 11'b10101010000, 64'hF0, 64'h3C, 64'h600, 64'd0, 1'b0,
           4'b0001, 64'hFC, 1'b0, 64'h604);
    run_op("unk",   2'b10, 11'b11111111111, 64'hF0, 64'h3C, 64'h700, 64'd0, 1'b0,
           4'b1111, 64'd0, 1'b1, 64'h704);
    run_op("subzero", 2'b10, 11'b11001011000, 64'h1234, 64'h1234, 64'h800, 64'd5, 1'b1,
           4'b0110, 64'd0, 1'b1, 64'h814);

    // Idle cycle: valid drops, outputs hold the last capture.
    @(negedge clock);
    in_valid = 1'b0; input_data_1 = 64'd77; input_data_2 = 64'd88; branch = 1'b0;
    @(posedge clock);
    #1;
    check_eq("idle_valid", 64'(out_valid), 64'd0);
    check_eq("idle_data",  output_data, 64'd0);
    check_eq("idle_zero",  64'(output_zero), 64'd1);
    check_eq("idle_newpc", new_pc, 64'h814);

    // Fresh valid result, then reset asserted between edges.
    run_op("pre_rst", 2'b00, 11'b0, 64'd40, 64'd2, 64'h900, 64'd0, 1'b0,
           4'b0010, 64'd42, 1'b0, 64'h904);
    #2;
    reset = 1'b0; in_valid = 1'b1;
    #1;
    check_eq("async_valid", 64'(out_valid), 64'd0);
    check_eq("async_data",  output_data, 64'd0);
    check_eq("async_zero",  64'(output_zero), 64'd0);
    check_eq("async_newpc", new_pc, 64'd0);
    @(posedge clock);
    #1;
    check_eq("inrst_valid", 64'(out_valid), 64'd0);
    check_eq("inrst_data",  output_data, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    run_op("post_rst", 2'b10, 11'b10001011000, 64'd3, 64'd4, 64'hA00, 64'd0, 1'b0,
           4'b0010, 64'd7, 1'b0, 64'hA04);

    // Decode is unaffected by reset.
    @(negedge clock);
    in_valid = 1'b0; reset = 1'b0;
    alu_op_1 = 1'b1; alu_op_0 = 1'b0; instruction_part = 11'b10101010000;
    #1;
    check_eq("op_in_rst", 64'(operation_code), 64'b0001);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
